// File: rtl/sram_if_pkg.sv
// sram_if_pkg: shared constants for the SRAM-like data port responder.
package sram_if_pkg;
  localparam logic [3:0]  SRAM_WEN_READ = 4'b0000;
  localparam logic [31:0] SRAM_ERR_DATA = 32'hDEAD_BEEF;
  localparam int          LANE_W        = 8;
  localparam int          LANES         = 4;
endpackage

// File: rtl/data_sram_resp_if.sv
// data_sram_resp_if: MEM-stage data SRAM-like port bundle.
interface data_sram_resp_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  modport master (output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, input data_sram_rdata);
  modport slave  (input data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, output data_sram_rdata);
endinterface

// File: rtl/sram_byte_array.sv
// sram_byte_array: 2^ADDR_W x 32 byte-writable array with registered write-first read port.
module sram_byte_array
  import sram_if_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [3:0]        wen,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [2**ADDR_W];
  logic [31:0] merged;
  always_comb begin
    merged = mem[idx];
    for (int i = 0; i < LANES; i++)
      merged[LANE_W*i +: LANE_W] = wen[i] ? wdata[LANE_W*i +: LANE_W] : merged[LANE_W*i +: LANE_W];
  end
  // contents survive reset; the whole merged word lands on one edge so a write is never torn
  always_ff @(posedge clk)
    if (en && wen != SRAM_WEN_READ) mem[idx] <= merged;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) rdata <= '0;
    else if (en) rdata <= merged;
endmodule

// File: rtl/data_sram_resp.sv
// data_sram_resp: data SRAM responder, 1-cycle read latency, access counters.
// Optional DATA_SRAM_RANGE_CHK_EN: out-of-range suppression, error data and sticky acc_err.
module data_sram_resp
  import sram_if_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  data_sram_resp_if.slave  bus,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic             acc_err
);
  logic [ADDR_W-1:0] idx;
  logic [3:0]        arr_wen;
  logic [31:0]       arr_rdata;
  logic              wr;
  assign idx = ADDR_W'((bus.data_sram_addr - BASE_ADDR) >> 2);
  assign wr  = bus.data_sram_wen != SRAM_WEN_READ;
`ifdef DATA_SRAM_RANGE_CHK_EN
  logic oor, oor_q;
  assign oor = {1'b0, bus.data_sram_addr} < {1'b0, BASE_ADDR} ||
               {1'b0, bus.data_sram_addr} >= {1'b0, BASE_ADDR} + (33'd1 << (ADDR_W + 2));
  assign arr_wen = oor ? SRAM_WEN_READ : bus.data_sram_wen;
  assign bus.data_sram_rdata = oor_q ? SRAM_ERR_DATA : arr_rdata;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      oor_q   <= 1'b0;
      acc_err <= 1'b0;
    end else if (bus.data_sram_en) begin
      oor_q   <= oor;
      acc_err <= acc_err | oor;
    end
`else
  assign arr_wen = bus.data_sram_wen;
  assign bus.data_sram_rdata = arr_rdata;
  assign acc_err = 1'b0;
`endif
  sram_byte_array #(.ADDR_W(ADDR_W)) u_arr (
    .clk   (clk),
    .resetn(resetn),
    .en    (bus.data_sram_en),
    .wen   (arr_wen),
    .idx   (idx),
    .wdata (bus.data_sram_wdata),
    .rdata (arr_rdata)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (bus.data_sram_en) begin
      rd_cnt <= wr ? rd_cnt : rd_cnt + CNT_W'(1);
      wr_cnt <= wr ? wr_cnt + CNT_W'(1) : wr_cnt;
    end
endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: directed plus random accesses against a word-array reference model.
module tb_data_sram_resp;
  localparam int          ADDR_W = 8;
  localparam int          CNT_W  = 4;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          DEPTH  = 2**ADDR_W;

  logic clk = 1'b0;
  logic resetn;
  logic [CNT_W-1:0] rd_cnt, wr_cnt;
  logic acc_err;
  data_sram_resp_if bus ();

  data_sram_resp #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .acc_err(acc_err)
  );

  always #5 clk = ~clk;

  logic [31:0] m_mem [DEPTH];
  int          m_rd, m_wr;
  logic [31:0] m_rdata;
  logic        m_err;
  int          checks = 0, passes = 0;
  logic [31:0] v34;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rdata"}, bus.data_sram_rdata, m_rdata);
    check({tag, ".rd_cnt"}, 32'(rd_cnt), 32'(m_rd % (2**CNT_W)));
    check({tag, ".wr_cnt"}, 32'(wr_cnt), 32'(m_wr % (2**CNT_W)));
    check({tag, ".acc_err"}, 32'(acc_err), 32'(m_err));
  endtask

  task automatic acc(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
    bit oor;
    int k;
    @(negedge clk);
    bus.data_sram_en = en; bus.data_sram_wen = wen;
    bus.data_sram_addr = addr; bus.data_sram_wdata = wdata;
    @(posedge clk); #1;
    if (en) begin
      oor = 1'b0;
`ifdef DATA_SRAM_RANGE_CHK_EN
      oor = (longint'(addr) < longint'(BASE)) || (longint'(addr) >= longint'(BASE) + 4 * DEPTH);
`endif
      if (wen == 4'b0000) m_rd++; else m_wr++;
      if (oor) begin
        m_rdata = 32'hDEAD_BEEF;
        m_err = 1'b1;
      end else begin
        k = int'(((addr - BASE) / 4) % DEPTH);
        for (int l = 0; l < 4; l++)
          if (wen[l]) m_mem[k][8*l +: 8] = wdata[8*l +: 8];
        m_rdata = m_mem[k];
      end
    end
    check_all("acc");
  endtask

  task automatic idle();
    acc(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.data_sram_en = 1'b0;
    #2 resetn = 1'b0;
    #1;
    m_rd = 0; m_wr = 0; m_rdata = '0; m_err = 1'b0;
    check_all("async_rst");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    bus.data_sram_en = 1'b0; bus.data_sram_wen = '0;
    bus.data_sram_addr = '0; bus.data_sram_wdata = '0;
    m_rd = 0; m_wr = 0; m_rdata = '0; m_err = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check_all("reset");

    acc(1'b1, 4'hF, 32'h10, 32'h1234_5678);
    acc(1'b1, 4'h0, 32'h10, 32'h0);
    check("t2.rdata", bus.data_sram_rdata, 32'h1234_5678);
    check("t2.wr_cnt", 32'(wr_cnt), 32'd1);
    check("t2.rd_cnt", 32'(rd_cnt), 32'd1);

    acc(1'b1, 4'hF, 32'h20, 32'hAABB_CCDD);
    acc(1'b1, 4'b0101, 32'h20, 32'h1122_3344);
    check("t3.write_first", bus.data_sram_rdata, 32'hAA22_CC44);
    acc(1'b1, 4'h0, 32'h20, 32'h0);
    check("t3.readback", bus.data_sram_rdata, 32'hAA22_CC44);

    v34 = $urandom;
    acc(1'b1, 4'hF, 32'h34, v34);
    acc(1'b1, 4'hF, 32'h30, 32'h0000_00FF);
    acc(1'b1, 4'h0, 32'h30, 32'h0);
    check("t4.dep_read", bus.data_sram_rdata, 32'h0000_00FF);
    acc(1'b1, 4'h0, 32'h34, 32'h0);
    check("t4.next_read", bus.data_sram_rdata, v34);
    idle();
    idle();
    check("t4.idle_hold", bus.data_sram_rdata, v34);

    do_reset();
    for (int i = 0; i < 17; i++) acc(1'b1, 4'h0, 32'h10, 32'h0);
    check("t5.rd_wrap", 32'(rd_cnt), 32'd1);
    check("t5.array_kept", bus.data_sram_rdata, 32'h1234_5678);

    for (int i = 0; i < DEPTH; i++) acc(1'b1, 4'hF, BASE + 32'(4 * i), $urandom);

`ifdef DATA_SRAM_RANGE_CHK_EN
    acc(1'b1, 4'hF, 32'h400, 32'h0000_CAFE);
    check("t6.oor_wr_err", 32'(acc_err), 32'd1);
    acc(1'b1, 4'h0, 32'h0, 32'h0);
    check("t6.word0_kept", bus.data_sram_rdata, m_mem[0]);
    acc(1'b1, 4'h0, 32'h400, 32'h0);
    check("t6.err_data", bus.data_sram_rdata, 32'hDEAD_BEEF);
    idle();
    check("t6.err_sticky", 32'(acc_err), 32'd1);
`else
    acc(1'b1, 4'hF, 32'h400, 32'h0000_CAFE);
    acc(1'b1, 4'h0, 32'h0, 32'h0);
    check("t6.alias", bus.data_sram_rdata, 32'h0000_CAFE);
    check("t6.no_err", 32'(acc_err), 32'd0);
`endif

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [3:0]  w;
      if (i == 150) do_reset();
      a = ($urandom % 16 == 0) ? $urandom : 32'(($urandom % 1280) * 4 + ($urandom % 4));
      w = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom);
      acc($urandom % 4 != 0, w, a, $urandom);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder end of the CPU's data SRAM-like port: accepts `data_sram_en`/`wen`/`addr`/`wdata` from the MEM stage and returns `data_sram_rdata` with the fixed one-cycle synchronous latency the MEM stage expects. It holds a byte-writable word array and keeps read/write access counters for the debug display. It replaces the vendor data-RAM IP in simulation and lite-SoC builds.

## Interface
Parameters:
- `ADDR_W`, 8, word-index width; array depth is 2^ADDR_W words.
- `BASE_ADDR`, 32'h0000_0000, byte address of word 0; must be aligned to 2^(ADDR_W+2).
- `CNT_W`, 16, access counter width.

Ports:
- `clk` in 1: single clock; all state on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `data_sram_en` in 1: access request this cycle.
- `data_sram_wen` in 4: byte write enables, bit i controls byte lane i ([8i+7:8i]); 0 means read.
- `data_sram_addr` in 32: byte address; bits [1:0] ignored.
- `data_sram_wdata` in 32: write data, lane-aligned.
- `data_sram_rdata` out 32: registered read data.
- `rd_cnt` out CNT_W: count of accepted reads.
- `wr_cnt` out CNT_W: count of accepted writes.
- `acc_err` out 1: sticky out-of-range flag (see Configuration).

## Operation
- Word index: `idx = (data_sram_addr - BASE_ADDR)[ADDR_W+1:2]`.
- Read (en=1, wen=0): `rdata` <= mem[idx] at the next edge. `rd_cnt` increments.
- Write (en=1, wen≠0): each lane with wen[i]=1 is written. Other lanes are unchanged. `wr_cnt` increments once per cycle, whatever the number of lanes.
- Write-first: in a write cycle, `rdata` <= the merged word (new lanes plus old lanes) at the next edge.
- Idle (en=0): `rdata` holds its last value. The array and counters are unchanged.
- A read in cycle N+1 of a word written in cycle N returns the updated word; no stale data.
- Counters wrap from 2^CNT_W−1 to 0 with no saturation.
- Array contents are not reset; they are unaffected by `resetn` and undefined at power-up.

## Timing
- Read latency is exactly 1 cycle: data is valid in the cycle after en=1 and stays valid until the next access. Back-to-back accesses are accepted every cycle.
- There is no handshake or stall. The responder is always ready.
- Reset values: `rdata`=0, `rd_cnt`=0, `wr_cnt`=0, `acc_err`=0. Assertion is asynchronous; release is sampled on the next `clk` edge.
- Reset asserted mid-access: the in-flight write is either fully committed or fully dropped (not torn). Outputs go to reset values immediately.
- The counters and the registered `rdata` path are the only sequential logic outside the array. There is no FSM beyond this.

## Configuration
- `DATA_SRAM_RANGE_CHK_EN` defined:
  - An access is out of range when `addr < BASE_ADDR` or `addr ≥ BASE_ADDR + 2^(ADDR_W+2)`.
  - Out-of-range writes are suppressed.
  - Out-of-range reads return 32'hDEAD_BEEF.
  - Any out-of-range access sets `acc_err` until reset.
  - Counters still count out-of-range accesses.
- Not defined:
  - Upper address bits are ignored, so accesses alias modulo the array size.
  - `acc_err` is tied to 0.

## Structure
- Shared package `sram_if_pkg`:
  - `SRAM_WEN_READ` = 4'b0000.
  - `SRAM_ERR_DATA` = 32'hDEAD_BEEF.
  - Lane width constant (8).
- One natural sub-module, `sram_byte_array`: a 2^ADDR_W×32 array with per-lane write enables and a registered write-first read port.
- The counters, range check and error flag stay in `data_sram_resp`.

## Test plan
1. Reset: hold `resetn`=0 for 3 cycles, then release → `rdata`=0, `rd_cnt`=0, `wr_cnt`=0, `acc_err`=0.
2. Full-word write then read:
   - Stimulus: write 32'h1234_5678 to 0x10, wen=4'hF; next cycle read 0x10.
   - Response: `rdata`=32'h1234_5678 one cycle after the read; `wr_cnt`=1, `rd_cnt`=1.
3. Byte-lane write with write-first:
   - Stimulus: preload 0x20 with 32'hAABB_CCDD, then write wdata=32'h1122_3344 with wen=4'b0101.
   - Response: `rdata` after the write cycle is 32'hAA22_CC44; a following read returns the same.
4. Back-to-back dependent access:
   - Stimulus: write 0x30 = 32'h0000_00FF in cycle N, read 0x30 in N+1, read 0x34 in N+2.
   - Response: `rdata`=32'hFF in N+2, then the 0x34 contents in N+3.
   - Idle for 2 cycles: `rdata` holds the 0x34 value.
5. Counter wrap: with CNT_W=4, issue 17 reads → `rd_cnt`=1.
6. Out-of-range access (ADDR_W=8, BASE=0):
   - With `DATA_SRAM_RANGE_CHK_EN`: write 32'hCAFE to 0x400 → word 0 unchanged. Read 0x400 → `rdata`=32'hDEAD_BEEF, `acc_err`=1 and stays 1.
   - Without the macro: the same write lands in word 0, and a read of 0x0 returns 32'hCAFE.
